// File: rtl/cross_bar_drain.sv
// Drain-side receiver for one crossbar output port: FWFT FIFO with hysteretic stall generation.
// Optional sticky drop detection is enabled by defining CROSS_BAR_DRAIN_OVERFLOW_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// FLOW  | stall=0, crossbar may send; leave when free slots <= STALL_LAT
// HOLD  | stall=1, waiting for occupancy to fall to DEPTH/2 or below
module cross_bar_drain #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int STALL_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid,
  input  logic [WIDTH-1:0]             q,
  output logic                         stall,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {FLOW = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push, pop;
  logic [CW-1:0]    cnt_n;

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  // A pop frees the slot, so a full FIFO can still take a word in the same cycle.
  assign push      = valid && ((count < CW'(DEPTH)) || pop);

  always_comb begin
    cnt_n = count;
    if (push && !pop)
      cnt_n = count + CW'(1);
    else if (pop && !push)
      cnt_n = count - CW'(1);
  end

  always_comb begin
    state_n = state;
    case (state)
      FLOW: if ((CW'(DEPTH) - cnt_n) <= CW'(STALL_LAT)) state_n = HOLD;
      HOLD: if (cnt_n <= CW'(DEPTH/2))                  state_n = FLOW;
      default: state_n = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= HOLD;
      stall  <= 1'b1;
    end else begin
      count <= cnt_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      state <= state_n;
      stall <= (state_n == HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr] <= q;
  end

`ifdef CROSS_BAR_DRAIN_OVERFLOW_EN
  // A valid word that could not be pushed was dropped on a full FIFO.
  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (valid && !push)
      overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cross_bar_drain.sv
// Directed scoreboard bench for cross_bar_drain (DEPTH=8, STALL_LAT=2).
module tb_cross_bar_drain;

  logic       clk = 1'b0;
  logic       rst, valid, out_ready;
  logic [7:0] q;
  logic       stall, out_valid, overflow;
  logic [7:0] out_data;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

`ifdef CROSS_BAR_DRAIN_OVERFLOW_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  cross_bar_drain #(.WIDTH(8), .DEPTH(8), .STALL_LAT(2)) dut (
    .clk(clk), .rst(rst), .valid(valid), .q(q), .stall(stall),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every downstream handshake consumes the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          check("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; valid = 1'b0; out_ready = 1'b0; q = 8'h00;

    // 1: reset
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_stall", {31'h0, stall}, 32'd1);
    end
    check("rst_count", {28'h0, count}, 32'd0);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_overflow", {31'h0, overflow}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_stall", {31'h0, stall}, 32'd0);

    // 2: single word passes straight through
    valid = 1'b1; q = 8'h01; out_ready = 1'b1; exp_q.push_back(8'h01);
    tick();
    valid = 1'b0;
    check("single_count1", {28'h0, count}, 32'd1);
    check("single_out_valid", {31'h0, out_valid}, 32'd1);
    tick();
    check("single_count0", {28'h0, count}, 32'd0);

    // 3: fill with no pop; stall rises after the 6th push
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      valid = 1'b1; q = 8'(k); exp_q.push_back(8'(k));
      tick();
      check("fill_stall", {31'h0, stall}, (k >= 6) ? 32'd1 : 32'd0);
    end
    valid = 1'b0;
    check("fill_count", {28'h0, count}, 32'd8);
    check("fill_overflow", {31'h0, overflow}, 32'd0);

    // 4: drain in order; stall releases at count<=4
    out_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      check("drain_count", {28'h0, count}, 32'(8 - j));
      check("drain_stall", {31'h0, stall}, (8 - j > 4) ? 32'd1 : 32'd0);
    end
    check("drain_out_valid", {31'h0, out_valid}, 32'd0);

    // 5: full FIFO, extra word is dropped
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      valid = 1'b1; q = 8'h10 + 8'(k); exp_q.push_back(8'h10 + 8'(k));
      tick();
    end
    valid = 1'b1; q = 8'hAA;
    tick();
    valid = 1'b0;
    check("drop_count", {28'h0, count}, 32'd8);
    check("drop_head", {24'h0, out_data}, 32'h10);
    check("drop_overflow", {31'h0, overflow}, {31'h0, EXP_OVF});

    // 6: push+pop at full keeps count, then mid-stream reset
    valid = 1'b1; q = 8'hBB; out_ready = 1'b1; exp_q.push_back(8'hBB);
    tick();
    check("full_pp_count", {28'h0, count}, 32'd8);
    q = 8'hCC; exp_q.push_back(8'hCC);
    tick();
    check("full_pp_count2", {28'h0, count}, 32'd8);
    check("sticky_overflow", {31'h0, overflow}, {31'h0, EXP_OVF});
    rst = 1'b1; valid = 1'b0;
    exp_q.delete();
    tick();
    check("mid_rst_count", {28'h0, count}, 32'd0);
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("mid_rst_overflow", {31'h0, overflow}, 32'd0);
    check("mid_rst_stall", {31'h0, stall}, 32'd1);
    rst = 1'b0;
    tick();
    check("mid_rst_release", {31'h0, stall}, 32'd0);

    // Post-reset traffic flows normally
    valid = 1'b1; q = 8'h5A; exp_q.push_back(8'h5A);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("final_count", {28'h0, count}, 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
